// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state encoding for the register-file writeback path.
package regfile_pkg;

  localparam int RF_NUM_REQ  = 3;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 8;
  localparam int RF_NUM_REGS = 32;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request after ptr, wrapping.
// Outputs a one-hot grant, its index, and a valid flag.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Sole owner of the register-file write port: round-robin writeback arbitration,
// clear sequencing of r1..r(NUM_REGS-1), optional forwarding (REGFILE_WB_BYPASS_EN).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ  = RF_NUM_REQ,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic                        clr_req,
  output logic                        clr_busy,
  output logic                        clr_done,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_rd,
  output logic [DATA_W-1:0]           rf_wdata,
  input  logic [ADDR_W-1:0]           fwd_rs,
  input  logic [ADDR_W-1:0]           fwd_rt,
  input  logic [DATA_W-1:0]           rf_rdata1,
  input  logic [DATA_W-1:0]           rf_rdata2,
  output logic [DATA_W-1:0]           fwd_data1,
  output logic [DATA_W-1:0]           fwd_data2
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_idx;
  logic [PTR_W-1:0]  rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_valid;
  logic              run;
  logic              handshake;
  logic              last_clr;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign run       = (state == ST_RUN);
  assign clr_busy  = (state == ST_CLEAR);
  assign req_ready = run ? grant : '0;
  assign handshake = run && grant_valid;
  assign last_clr  = (clr_idx == ADDR_W'(NUM_REGS - 1));
  assign sel_rd    = req_rd[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[grant_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_idx  <= ADDR_W'(1);
      rr_ptr   <= PTR_W'(NUM_REQ - 1);
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      clr_done <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here make rf_we and clr_done single-cycle pulses
      // unless a branch below re-asserts them in the same edge.
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      clr_done <= 1'b0;
      if (state == ST_CLEAR) begin
        rf_we   <= 1'b1;
        rf_rd   <= clr_idx;
        clr_idx <= clr_idx + 1'b1;
        if (last_clr) begin
          state    <= ST_RUN;
          clr_done <= 1'b1;
        end
      end else begin
        if (handshake) begin
          rr_ptr <= grant_idx;
          // Writes to r0 are accepted but dropped.
          if (sel_rd != '0) begin
            rf_we    <= 1'b1;
            rf_rd    <= sel_rd;
            rf_wdata <= sel_data;
          end
        end
        if (clr_req) begin
          state   <= ST_CLEAR;
          clr_idx <= ADDR_W'(1);
        end
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd_data1 = (rf_we && rf_rd == fwd_rs && rf_rd != '0) ? rf_wdata : rf_rdata1;
  assign fwd_data2 = (rf_we && rf_rd == fwd_rt && rf_rd != '0) ? rf_wdata : rf_rdata2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs, fwd_rt};
  assign fwd_data1  = rf_rdata1;
  assign fwd_data2  = rf_rdata2;
`endif

endmodule
